time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Button-driven time-setting controller for the digital clock. Sits between the debounced push-buttons and the clock core's overwrite port. Sequences the user through hour edit and minute edit, then issues a single-cycle overwrite of the running time with the edited value. Seconds are zeroed on commit; an inactivity timeout abandons an edit without committing.

## Interface
Parameters:
- `TIMEOUT_S`, default 10: whole seconds of no button activity before an edit is abandoned; legal range 1..63.
- `REPEAT_DLY`, default 50_000_000: clk cycles `btn_inc` must be held before auto-repeat starts. Used only with `TIME_SET_AUTOREPEAT_EN`.
- `REPEAT_PER`, default 10_000_000: clk cycles between auto-repeat increments. Used only with `TIME_SET_AUTOREPEAT_EN`.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: one-clk-wide pulse once per second, synchronous to `clk`.
- `btn_mode` input 1: debounced level, synchronous.
- `btn_inc` input 1: debounced level, synchronous.
- `cur_time` input 17: live time as [16:12] hour, [11:6] min, [5:0] sec.
- `time_ow` output 1: one-cycle overwrite strobe to the clock core.
- `time_in` output 17: overwrite value, same packing as `cur_time`.
- `edit_hr` output 1: high in SET_HR.
- `edit_min` output 1: high in SET_MIN.
- `blink` output 1: display-blank phase for the field being edited.

## Operation
- The two buttons are rising-edge detected against a registered copy: `press = btn & ~btn_q`.
- FSM states: RUN, SET_HR, SET_MIN, COMMIT.
- **RUN:**
  - On a `btn_mode` press, capture `cur_time` hour and minute into edit registers and go to SET_HR.
  - `btn_inc` is ignored in RUN.
- **SET_HR:**
  - An inc press gives hour+1, wrapping 23 to 0.
  - A mode press goes to SET_MIN.
- **SET_MIN:**
  - An inc press gives min+1, wrapping 59 to 0. Hour is unaffected; there is no carry.
  - A mode press goes to COMMIT.
- **COMMIT:**
  - Lasts exactly one cycle.
  - `time_ow`=1 and `time_in`={hour_e, min_e, 6'd0}. Next state is RUN.
- **Timeout:**
  - A 6-bit idle counter clears on any press, and on entering SET_HR.
  - In SET_HR or SET_MIN it increments on each `tick_1hz`.
  - When it reaches `TIMEOUT_S`, go to RUN with no overwrite.
- **Simultaneous mode and inc press:** mode wins and inc is discarded.
- **`tick_1hz` in the same cycle as a press:** the press clears the counter and the tick is not counted.
- **Blink:** toggles on each `tick_1hz` while in SET_HR or SET_MIN. It is forced to 0 in RUN and COMMIT, and cleared on entry to each edit state.
- **Outputs:**
  - `time_in` holds the last committed value between commits. Only the `time_ow` strobe is meaningful.
  - `edit_hr` and `edit_min` decode directly from the state register.
- **Edit-register range:** the edit registers are always in range. An out-of-range captured `cur_time` field (hour >23, min >59) is clamped to 0 at capture.

## Timing
- **Reset values:** state=RUN, `time_ow`=0, `time_in`=0, `edit_hr`=0, `edit_min`=0, `blink`=0. Edit registers, idle counter and btn_q registers are all 0.
- **Reset mid-edit:** return to RUN on the next edge. No `time_ow` is issued.
- **Button latency:** a button first sampled high at edge N changes the state or edit register at edge N. The effect is visible in cycle N+1.
- **`time_ow`:**
  - Asserted for the single cycle after the edge that enters COMMIT, i.e. one cycle after the second mode press in an edit is visible.
  - Never asserted for two consecutive cycles.
- **Mode press during COMMIT:** discarded. The state returns to RUN.
- **Holding a button:** produces exactly one press unless auto-repeat is enabled.

## Configuration
- **`TIME_SET_AUTOREPEAT_EN` defined:**
  - While `btn_inc` is held in SET_HR or SET_MIN, a repeat counter runs.
  - After `REPEAT_DLY` cycles it issues a synthetic inc press, then one every `REPEAT_PER` cycles.
  - Synthetic presses clear the idle counter.
  - Releasing `btn_inc`, or any state change, resets the repeat counter.
- **Not defined:** no repeat counter is generated and `REPEAT_DLY`/`REPEAT_PER` are unused.

## Structure
- **Package `time_ctrl_pkg`:**
  - State enum.
  - `HR_W`=5, `MIN_W`=6, `SEC_W`=6.
  - Field offsets `HR_LSB`=12, `MIN_LSB`=6.
  - `HR_MAX`=23, `MIN_MAX`=59.
  - Pack/unpack helper functions.
- **Sub-module `btn_press`:** per-button edge detect, plus auto-repeat under the macro. Instantiated twice; auto-repeat is enabled only on the inc instance.

## Test plan
- **Basic edit:** reset; `cur_time`=12:30:45; pulse mode, inc×3, mode, inc×2, mode. Expect `time_ow`=1 for exactly one cycle with `time_in`={15, 32, 0}, then state RUN.
- **Wrap:** capture 23:59; one inc in SET_HR, one in SET_MIN, commit. Expect `time_in`={0, 0, 0}.
- **Timeout:** enter SET_HR and apply `TIMEOUT_S`=10 ticks with no press. Expect RUN after the 10th tick and `time_ow` never asserted. With a press at tick 9, the timeout occurs 10 ticks after that press.
- **Simultaneous mode+inc in SET_HR:** expect SET_MIN with the hour unchanged.
- **Reset mid-edit:** assert `rst` in SET_MIN. Expect all outputs 0 next cycle and no `time_ow`.
- **Held inc:** with the macro, use `REPEAT_DLY`=20 and `REPEAT_PER`=5 and hold 35 cycles. Expect 1 + 4 increments. Without the macro, expect 1 increment.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared types, field geometry and pack/unpack helpers for the time-setting controller.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN,
    ST_COMMIT
  } state_t;

  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int TIME_W  = HR_W + MIN_W + SEC_W;
  localparam int HR_LSB  = 12;
  localparam int MIN_LSB = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  function automatic logic [TIME_W-1:0] pack_time(input logic [HR_W-1:0]  hr,
                                                  input logic [MIN_W-1:0] mn,
                                                  input logic [SEC_W-1:0] sec);
    return {hr, mn, sec};
  endfunction

  function automatic logic [HR_W-1:0] get_hr(input logic [TIME_W-1:0] t);
    return t[HR_LSB +: HR_W];
  endfunction

  function automatic logic [MIN_W-1:0] get_min(input logic [TIME_W-1:0] t);
    return t[MIN_LSB +: MIN_W];
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_press.sv
// Per-button rising-edge detector. With TIME_SET_AUTOREPEAT_EN defined and
// REPEAT_EN set, a held button also emits synthetic presses after REPEAT_DLY
// held cycles and every REPEAT_PER cycles thereafter.
module btn_press
`ifdef TIME_SET_AUTOREPEAT_EN
#(
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
`ifdef TIME_SET_AUTOREPEAT_EN
  input  logic i_hold_en,
  input  logic i_hold_clr,
`endif
  output logic o_press
);

  logic r_btn_q;
  logic w_edge;

  // Registered copy of the button level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) r_btn_q <= 1'b0;
    else     r_btn_q <= i_btn;
  end

  assign w_edge = i_btn & ~r_btn_q;

`ifdef TIME_SET_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int unsigned MAXC = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_rep;
    logic          w_fire;

    // r_cnt holds the number of earlier held cycles in the current phase, so a
    // match on DLY-1 / PER-1 fires on the DLY-th / PER-th held cycle.
    always_comb begin
      w_fire = 1'b0;
      if (i_btn && i_hold_en)
        w_fire = r_rep ? (r_cnt == CW'(REPEAT_PER - 1)) : (r_cnt == CW'(REPEAT_DLY - 1));
    end

    // Repeat counter: runs while held in an edit state, restarts on release or state change.
    always_ff @(posedge clk) begin
      if (rst || !i_btn || !i_hold_en || i_hold_clr) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_fire) begin
        r_cnt <= '0;
        r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign o_press = w_edge | w_fire;
  end else begin : g_norep
    assign o_press = w_edge;
  end
`else
  assign o_press = w_edge;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: RUN -> SET_HR -> SET_MIN -> COMMIT.
// Optional auto-repeat on btn_inc is built when TIME_SET_AUTOREPEAT_EN is defined.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [16:0] cur_time,
  output logic        time_ow,
  output logic [16:0] time_in,
  output logic        edit_hr,
  output logic        edit_min,
  output logic        blink
);

  state_t             r_state, w_next;
  logic [HR_W-1:0]    r_hr, w_hr, w_cap_hr;
  logic [MIN_W-1:0]   r_min, w_min, w_cap_min;
  logic [5:0]         r_idle, w_idle;
  logic               r_blink, w_blink;
  logic               r_ow, w_ow;
  logic [TIME_W-1:0]  r_tin, w_tin;
  logic               w_mode_p, w_inc_p;
  logic               w_edit, w_next_edit, w_timeout;

  btn_press u_mode (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (btn_mode),
`ifdef TIME_SET_AUTOREPEAT_EN
    .i_hold_en  (1'b0),
    .i_hold_clr (1'b0),
`endif
    .o_press    (w_mode_p)
  );

`ifdef TIME_SET_AUTOREPEAT_EN
  btn_press #(
    .REPEAT_EN  (1'b1),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (btn_inc),
    .i_hold_en  (w_edit),
    .i_hold_clr (w_next != r_state),
    .o_press    (w_inc_p)
  );
`else
  btn_press u_inc (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .o_press (w_inc_p)
  );
`endif

  assign w_edit      = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
  assign w_next_edit = (w_next == ST_SET_HR) || (w_next == ST_SET_MIN);
  assign w_timeout   = tick_1hz && (r_idle == 6'(TIMEOUT_S - 1));
  assign w_cap_hr    = get_hr(cur_time);
  assign w_cap_min   = get_min(cur_time);

  // Next-state, edit registers, idle counter, blink and commit strobe.
  always_comb begin
    w_next  = r_state;
    w_hr    = r_hr;
    w_min   = r_min;
    w_ow    = 1'b0;
    w_tin   = r_tin;
    w_idle  = r_idle;
    w_blink = r_blink;

    // Mode outranks inc; any press outranks a same-cycle timeout tick.
    unique case (r_state)
      ST_RUN: begin
        if (w_mode_p) begin
          w_hr   = (w_cap_hr  > HR_MAX)  ? '0 : w_cap_hr;
          w_min  = (w_cap_min > MIN_MAX) ? '0 : w_cap_min;
          w_next = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (w_mode_p)     w_next = ST_SET_MIN;
        else if (w_inc_p) w_hr   = (r_hr == HR_MAX) ? '0 : r_hr + 5'd1;
        else if (w_timeout) w_next = ST_RUN;
      end
      ST_SET_MIN: begin
        if (w_mode_p) begin
          w_next = ST_COMMIT;
          w_ow   = 1'b1;
          w_tin  = pack_time(r_hr, r_min, '0);
        end
        else if (w_inc_p)   w_min  = (r_min == MIN_MAX) ? '0 : r_min + 6'd1;
        else if (w_timeout) w_next = ST_RUN;
      end
      ST_COMMIT: w_next = ST_RUN;
      default:   w_next = ST_RUN;
    endcase

    if (w_mode_p || w_inc_p)   w_idle = '0;
    else if (w_edit && tick_1hz) w_idle = r_idle + 6'd1;

    if ((w_next != r_state) || !w_next_edit) w_blink = 1'b0;
    else if (tick_1hz)                       w_blink = ~r_blink;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_hr    <= '0;
      r_min   <= '0;
      r_idle  <= '0;
      r_blink <= 1'b0;
      r_ow    <= 1'b0;
      r_tin   <= '0;
    end else begin
      r_state <= w_next;
      r_hr    <= w_hr;
      r_min   <= w_min;
      r_idle  <= w_idle;
      r_blink <= w_blink;
      r_ow    <= w_ow;
      r_tin   <= w_tin;
    end
  end

  assign time_ow  = r_ow;
  assign time_in  = r_tin;
  assign edit_hr  = (r_state == ST_SET_HR);
  assign edit_min = (r_state == ST_SET_MIN);
  assign blink    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus a randomized
// run, all compared against a behavioural model of the user-visible rules.
module tb_time_set_ctrl;

  localparam int TO  = 10;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic        clk = 1'b0;
  logic        rst, tick, bm, bi;
  logic [16:0] cur;
  logic        time_ow, edit_hr, edit_min, blink;
  logic [16:0] time_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: st 0=RUN 1=SET_HR 2=SET_MIN 3=COMMIT
  int m_st, m_hr, m_mn, m_idle, m_blink, m_ow, m_tin, m_mq, m_iq, m_held;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_S(TO), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(bm), .btn_inc(bi),
    .cur_time(cur), .time_ow(time_ow), .time_in(time_in),
    .edit_hr(edit_hr), .edit_min(edit_min), .blink(blink)
  );

  task automatic model_step(input logic m, input logic i, input logic t, input logic r);
    int mp, ip, nst, ch, cm;
    if (r) begin
      m_st = 0; m_hr = 0; m_mn = 0; m_idle = 0; m_blink = 0;
      m_ow = 0; m_tin = 0; m_mq = 0; m_iq = 0; m_held = 0;
      return;
    end
    mp = (m && !m_mq) ? 1 : 0;
    ip = (i && !m_iq) ? 1 : 0;
`ifdef TIME_SET_AUTOREPEAT_EN
    if (i && (m_st == 1 || m_st == 2)) begin
      m_held++;
      if (m_held == DLY || (m_held > DLY && (m_held - DLY) % PER == 0)) ip = 1;
    end else m_held = 0;
`endif
    m_mq = m; m_iq = i;
    nst = m_st;
    case (m_st)
      0: if (mp != 0) begin
           ch = int'(cur[16:12]); cm = int'(cur[11:6]);
           m_hr = (ch > 23) ? 0 : ch;
           m_mn = (cm > 59) ? 0 : cm;
           nst = 1;
         end
      1: if (mp != 0) nst = 2;
         else if (ip != 0) m_hr = (m_hr + 1) % 24;
         else if (t && m_idle + 1 == TO) nst = 0;
      2: if (mp != 0) nst = 3;
         else if (ip != 0) m_mn = (m_mn + 1) % 60;
         else if (t && m_idle + 1 == TO) nst = 0;
      default: nst = 0;
    endcase
    if (mp != 0 || ip != 0) m_idle = 0;
    else if ((m_st == 1 || m_st == 2) && t) m_idle++;
    if (nst != m_st || !(nst == 1 || nst == 2)) m_blink = 0;
    else if (t) m_blink = 1 - m_blink;
    m_ow = (nst == 3) ? 1 : 0;
    if (m_ow != 0) m_tin = m_hr * 4096 + m_mn * 64;
`ifdef TIME_SET_AUTOREPEAT_EN
    if (nst != m_st) m_held = 0;
`endif
    m_st = nst;
  endtask

  task automatic cyc(input logic m, input logic i, input logic t, input logic r);
    bm = m; bi = i; tick = t; rst = r;
    @(posedge clk);
    model_step(m, i, t, r);
    @(negedge clk);
  endtask

  function automatic logic [20:0] exp_vec();
    logic [16:0] tin;
    tin = 17'(m_tin);
    return {(m_ow != 0), tin, (m_st == 1), (m_st == 2), (m_blink != 0)};
  endfunction

  task automatic test_reset();
    cur = 17'h1ABCD;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    n_checks++;
    if ({time_ow, time_in, edit_hr, edit_min, blink} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", {time_ow, time_in, edit_hr, edit_min, blink});
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (edit_hr !== 1'b0 || time_ow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release edit_hr=%b time_ow=%b want 0/0", edit_hr, time_ow);
    end
  endtask

  task automatic test_basic_edit();
    int ow_cnt;
    ow_cnt = 0;
    cur = {5'd12, 6'd30, 6'd45};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    n_checks++;
    if (edit_hr !== 1'b1 || edit_min !== 1'b0) begin
      n_fail++; $display("FAIL basic_enter_hr edit_hr=%b edit_min=%b want 1/0", edit_hr, edit_min);
    end
    for (int k = 0; k < 3; k++) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    cyc(1, 0, 0, 0);
    n_checks++;
    if (edit_min !== 1'b1) begin
      n_fail++; $display("FAIL basic_enter_min edit_min=%b want 1", edit_min);
    end
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    cyc(1, 0, 0, 0);
    if (time_ow === 1'b1) ow_cnt++;
    n_checks++;
    if (time_ow !== 1'b1 || time_in !== {5'd15, 6'd32, 6'd0}) begin
      n_fail++; $display("FAIL basic_commit time_ow=%b time_in=%h want 1/%h", time_ow, time_in, {5'd15, 6'd32, 6'd0});
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      if (time_ow === 1'b1) ow_cnt++;
    end
    n_checks++;
    if (ow_cnt != 1 || edit_hr !== 1'b0 || edit_min !== 1'b0 || time_in !== {5'd15, 6'd32, 6'd0}) begin
      n_fail++; $display("FAIL basic_after ow_cnt=%0d edit=%b%b time_in=%h want 1/00/held", ow_cnt, edit_hr, edit_min, time_in);
    end
  endtask

  task automatic test_wrap();
    cur = {5'd23, 6'd59, 6'd10};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (time_ow !== 1'b1 || time_in !== 17'd0) begin
      n_fail++; $display("FAIL wrap_commit time_ow=%b time_in=%h want 1/0", time_ow, time_in);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int ow_seen;
    ow_seen = 0;
    cur = {5'd8, 6'd15, 6'd0};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 0, 1, 0);
      if (time_ow === 1'b1) ow_seen++;
      n_checks++;
      if (edit_hr !== (k < TO) || blink !== (exp_vec() & 21'd1) != 0) begin
        n_fail++; $display("FAIL timeout_tick%0d edit_hr=%b blink=%b want %b/%b", k, edit_hr, blink, (k < TO), m_blink[0]);
      end
      cyc(0, 0, 0, 0);
    end
    // Second pass: press on the 9th tick restarts the timeout window.
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); end
    cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 0, 1, 0);
      if (time_ow === 1'b1) ow_seen++;
      if (k >= TO - 1) begin
        n_checks++;
        if (edit_hr !== (k < TO)) begin
          n_fail++; $display("FAIL timeout_restart_tick%0d edit_hr=%b want %b", k, edit_hr, (k < TO));
        end
      end
      cyc(0, 0, 0, 0);
    end
    n_checks++;
    if (ow_seen != 0 || time_in !== 17'd0) begin
      n_fail++; $display("FAIL timeout_no_ow ow_seen=%0d time_in=%h want 0/0", ow_seen, time_in);
    end
  endtask

  task automatic test_simultaneous();
    cur = {5'd7, 6'd20, 6'd33};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    n_checks++;
    if (edit_min !== 1'b1 || edit_hr !== 1'b0) begin
      n_fail++; $display("FAIL simul_state edit_hr=%b edit_min=%b want 0/1", edit_hr, edit_min);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (time_ow !== 1'b1 || time_in !== {5'd7, 6'd20, 6'd0}) begin
      n_fail++; $display("FAIL simul_commit time_ow=%b time_in=%h want 1/%h", time_ow, time_in, {5'd7, 6'd20, 6'd0});
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_edit();
    int ow_seen;
    ow_seen = 0;
    cur = {5'd3, 6'd4, 6'd5};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 1);
    if (time_ow === 1'b1) ow_seen++;
    n_checks++;
    if ({time_ow, time_in, edit_hr, edit_min, blink} !== 21'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs got=%h want=0", {time_ow, time_in, edit_hr, edit_min, blink});
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      if (time_ow === 1'b1) ow_seen++;
    end
    n_checks++;
    if (ow_seen != 0 || edit_hr !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after ow_seen=%0d edit_hr=%b want 0/0", ow_seen, edit_hr);
    end
  endtask

  task automatic test_held_inc();
    logic [4:0] want_hr;
`ifdef TIME_SET_AUTOREPEAT_EN
    want_hr = 5'd10;
`else
    want_hr = 5'd6;
`endif
    cur = {5'd5, 6'd10, 6'd0};
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    for (int k = 0; k < 35; k++) begin
      cyc(0, 1, 0, 0);
      n_checks++;
      if ({time_ow, time_in, edit_hr, edit_min, blink} !== exp_vec()) begin
        n_fail++; $display("FAIL held_cycle%0d got=%h want=%h", k, {time_ow, time_in, edit_hr, edit_min, blink}, exp_vec());
      end
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (time_ow !== 1'b1 || time_in !== {want_hr, 6'd10, 6'd0}) begin
      n_fail++; $display("FAIL held_commit time_ow=%b time_in=%h want 1/%h", time_ow, time_in, {want_hr, 6'd10, 6'd0});
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic m, i, t, r, prev_ow;
    i = 1'b0; prev_ow = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      cur = 17'($urandom);
      m = ($urandom % 30 == 0);
      if ($urandom % 10 == 0) i = ~i;
      t = ($urandom % 4 == 0);
      r = ($urandom % 700 == 0);
      cyc(m, i, t, r);
      n_checks++;
      if ({time_ow, time_in, edit_hr, edit_min, blink} !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d got=%h want=%h", k, {time_ow, time_in, edit_hr, edit_min, blink}, exp_vec());
      end
      if (prev_ow && time_ow) begin
        n_fail++; $display("FAIL random_ow_double cycle%0d time_ow=1 want 0", k);
      end
      prev_ow = time_ow;
    end
  endtask

  initial begin
    bm = 0; bi = 0; tick = 0; rst = 1; cur = '0;
    @(negedge clk);
    test_reset();
    test_basic_edit();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_edit();
    test_held_inc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
